clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//  Multi-channel programmable clock-enable generator. Derives per-channel
//  single-cycle tick pulses and 50%-duty toggle outputs from the system clock.
//  Divisors are loadable at runtime (e.g. game drop speed per level, key-scan
//  rate, display refresh) with a global pause and per-channel restart.
// PARAMETERS
//  NCH     3     number of independent divider channels (1..8)
//  CNT_W   27    counter/divisor width in bits
//  DEF_DIV 2     divisor loaded into every channel at reset (must be < 2**CNT_W)
//  SEL_W   2     div_sel width; must satisfy 2**SEL_W >= NCH
// PORTS
//  clk       in   1       system clock; all state updates on posedge
//  rst       in   1       asynchronous, active-high reset
//  en        in   1       global run enable; 0 = all channels paused
//  ch_clr    in   NCH     per-channel synchronous restart
//  div_wr    in   1       divisor write strobe (one cycle)
//  div_sel   in   SEL_W   channel index for div_wr
//  div_data  in   CNT_W   new divisor value
//  tick      out  NCH     one-cycle enable pulse per channel (registered)
//  clk_out   out  NCH     toggles on every tick; period 2*div cycles (registered)
// BEHAVIOUR
//  Reset (async, rst=1): cnt[i]=0, div[i]=DEF_DIV, tick=0, clk_out=0, all i.
//  Per channel i, each posedge, priority highest first:
//   1. div_wr && div_sel==i: div[i]<=div_data; cnt[i]<=0; tick[i]<=0;
//      clk_out[i] held. Takes effect from next cycle; any tick that would have
//      fired this cycle is suppressed.
//   2. ch_clr[i]: cnt[i]<=0; tick[i]<=0; clk_out[i]<=0.
//   3. en==0 or div[i]==0: cnt[i], clk_out[i] hold; tick[i]<=0.
//   4. cnt[i]==div[i]-1: cnt[i]<=0; tick[i]<=1; clk_out[i]<=~clk_out[i].
//   5. otherwise: cnt[i]<=cnt[i]+1; tick[i]<=0.
//  Timing: with divisor N>=1 and en=1 from reset release, tick[i] is high in
//   the cycle after posedges N, 2N, 3N...; exactly one high cycle per N cycles.
//  div=1: tick constantly 1, clk_out toggles every cycle (clk/2, legacy mode).
//  div=0: channel disabled; tick=0, outputs frozen.
//  Counter compare is exact-equality in CNT_W bits; no overflow possible since
//   cnt is restarted on every divisor write. div_data=2**CNT_W-1 is legal.
//  div_sel >= NCH: write ignored, no channel affected.
//  Simultaneous div_wr and ch_clr on same channel: rule 1 applies, then
//   clk_out[i] also cleared (clr's clk_out effect is kept).
//  en deasserted mid-count: count resumes from held value when en returns;
//   no extra or lost tick besides the paused interval.
//  Channels fully independent; no combinational path input->output.
// TESTING
//  1. Assert rst mid-run -> tick=0, clk_out=0 immediately (async); after
//     release with DEF_DIV=2, en=1: tick[i]=1 every 2nd cycle, clk_out period 4.
//  2. Write div=1 to ch0 -> from 2nd cycle after write tick[0]=1 every cycle,
//     clk_out[0] toggles every cycle; ch1/ch2 unaffected.
//  3. Write div=5 to ch1 when cnt[1]=1 -> no tick that cycle, next ticks
//     exactly 5,10,15 cycles after write edge; clk_out[1] period 10.
//  4. Drop en for 7 cycles while ch2 div=4, cnt=2 -> no ticks during pause;
//     first tick 2 cycles after en returns.
//  5. Write div=0 to ch0 -> tick[0] stays 0, clk_out[0] frozen 20 cycles;
//     write div=3 -> ticks resume every 3 cycles.
//  6. Same cycle div_wr(ch1,3)+ch_clr[1]+would-tick -> tick[1]=0, clk_out[1]=0,
//     div[1]=3; div_sel=3 with NCH=3 -> no divisor changes.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable generator: per-channel one-cycle ticks
// and 50%-duty toggle outputs, with runtime divisor load, global pause and restart.
module clk_div_multi #(
    parameter int NCH     = 3,
    parameter int CNT_W   = 27,
    parameter int DEF_DIV = 2,
    parameter int SEL_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   ch_clr,
    input  logic             div_wr,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [CNT_W-1:0] div_data,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   clk_out
);

    logic [CNT_W-1:0] cnt [NCH];
    logic [CNT_W-1:0] div [NCH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
                div[i] <= CNT_W'(DEF_DIV);
            end
            tick    <= '0;
            clk_out <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                // div_sel values past the last channel match no index, so they are ignored
                if (div_wr && (div_sel == SEL_W'(i))) begin
                    div[i]  <= div_data;
                    cnt[i]  <= '0;
                    tick[i] <= 1'b0;
                    if (ch_clr[i]) begin
                        clk_out[i] <= 1'b0;
                    end
                end else if (ch_clr[i]) begin
                    cnt[i]     <= '0;
                    tick[i]    <= 1'b0;
                    clk_out[i] <= 1'b0;
                end else if (!en || (div[i] == '0)) begin
                    tick[i] <= 1'b0;
                end else if (cnt[i] == (div[i] - CNT_W'(1))) begin
                    cnt[i]     <= '0;
                    tick[i]    <= 1'b1;
                    clk_out[i] <= ~clk_out[i];
                end else begin
                    cnt[i]  <= cnt[i] + CNT_W'(1);
                    tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi; inputs change and outputs are
// sampled on the falling edge, so each check sees the result of the last rising edge.
module tb_clk_div_multi;

    localparam int NCH     = 3;
    localparam int CNT_W   = 27;
    localparam int DEF_DIV = 2;
    localparam int SEL_W   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [NCH-1:0]   ch_clr;
    logic             div_wr;
    logic [SEL_W-1:0] div_sel;
    logic [CNT_W-1:0] div_data;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   clk_out;

    int n_assert = 0;
    int n_fail   = 0;

    clk_div_multi #(
        .NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .ch_clr(ch_clr), .div_wr(div_wr),
        .div_sel(div_sel), .div_data(div_data), .tick(tick), .clk_out(clk_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle divisor write; the write edge is consumed here.
    task automatic write_div(input int ch, input int val);
        div_wr   = 1'b1;
        div_sel  = SEL_W'(ch);
        div_data = CNT_W'(val);
        step();
        div_wr   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; ch_clr = '0; div_wr = 1'b0; div_sel = '0; div_data = '0;

        // Reset state, then default divisor 2 on every channel
        @(negedge clk);
        chk("reset_tick", 32'(tick), 0);
        chk("reset_clk_out", 32'(clk_out), 0);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("def_tick", 32'(tick), (k % 2 == 0) ? 7 : 0);
            chk("def_clk_out", 32'(clk_out), (k % 4 >= 2) ? 7 : 0);
        end

        // Asynchronous reset mid-run clears outputs without a clock edge
        #1 rst = 1'b1;
        #1;
        chk("async_tick", 32'(tick), 0);
        chk("async_clk_out", 32'(clk_out), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("rerun_tick", 32'(tick), (k % 2 == 0) ? 7 : 0);
            chk("rerun_clk_out", 32'(clk_out), (k % 4 >= 2) ? 7 : 0);
        end

        // div=1 on ch0: tick every cycle from the 2nd cycle after the write
        write_div(0, 1);
        chk("d1_w_tick", 32'(tick), 32'b000);
        chk("d1_w_clk", 32'(clk_out), 32'b000);
        step();
        chk("d1_1_tick", 32'(tick), 32'b111);
        chk("d1_1_clk", 32'(clk_out), 32'b111);
        step();
        chk("d1_2_tick", 32'(tick), 32'b001);
        chk("d1_2_clk", 32'(clk_out), 32'b110);
        step();
        chk("d1_3_tick", 32'(tick), 32'b111);
        chk("d1_3_clk", 32'(clk_out), 32'b001);
        step();
        chk("d1_4_tick", 32'(tick), 32'b001);
        chk("d1_4_clk", 32'(clk_out), 32'b000);

        // div=5 on ch1 while it is about to tick: that tick is suppressed
        write_div(1, 5);
        chk("d5_w_tick", 32'(tick), 32'b101);
        chk("d5_w_clk", 32'(clk_out), 32'b101);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("d5_tick1", 32'(tick[1]), (k % 5 == 0) ? 1 : 0);
            chk("d5_clk1", 32'(clk_out[1]), ((k / 5) % 2 == 1) ? 1 : 0);
        end

        // Pause with ch2 div=4, cnt=2
        write_div(2, 4);
        step();
        step();
        chk("pre_pause_tick", 32'(tick), 32'b001);
        chk("pre_pause_clk", 32'(clk_out), 32'b011);
        en = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("pause_tick", 32'(tick), 0);
            chk("pause_clk", 32'(clk_out), 32'b011);
        end
        en = 1'b1;
        step();
        chk("resume1_tick", 32'(tick), 32'b001);
        chk("resume1_clk", 32'(clk_out), 32'b010);
        step();
        chk("resume2_tick", 32'(tick), 32'b111);
        chk("resume2_clk", 32'(clk_out), 32'b101);

        // div=0 disables ch0 with its output frozen high, then div=3 resumes
        write_div(0, 0);
        chk("d0_w_tick0", 32'(tick[0]), 0);
        chk("d0_w_clk0", 32'(clk_out[0]), 1);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("d0_tick0", 32'(tick[0]), 0);
            chk("d0_clk0", 32'(clk_out[0]), 1);
        end
        write_div(0, 3);
        chk("d3_w_tick0", 32'(tick[0]), 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("d3_tick0", 32'(tick[0]), (k % 3 == 0) ? 1 : 0);
            chk("d3_clk0", 32'(clk_out[0]), (k < 3) ? 1 : ((k < 6) ? 0 : 1));
        end

        // ch_clr alone restarts ch1 from zero
        ch_clr = 3'b010;
        step();
        ch_clr = '0;
        chk("clr_tick1", 32'(tick[1]), 0);
        chk("clr_clk1", 32'(clk_out[1]), 0);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("clr_run_tick1", 32'(tick[1]), (k == 5) ? 1 : 0);
        end
        chk("pre_combo_clk1", 32'(clk_out[1]), 1);

        // Write + clear on ch1 in the cycle it would tick
        ch_clr = 3'b010;
        write_div(1, 3);
        ch_clr = '0;
        chk("combo_tick1", 32'(tick[1]), 0);
        chk("combo_clk1", 32'(clk_out[1]), 0);
        step();
        chk("combo1_tick1", 32'(tick[1]), 0);
        step();
        chk("combo2_tick1", 32'(tick[1]), 0);
        step();
        chk("combo3_tick1", 32'(tick[1]), 1);
        chk("combo3_clk1", 32'(clk_out[1]), 1);

        // div_sel=3 matches no channel: ch0 still ticks, ch1 keeps div=3
        write_div(3, 7);
        chk("sel3_tick0", 32'(tick[0]), 1);
        chk("sel3_tick1", 32'(tick[1]), 0);
        step();
        chk("sel3_1_tick1", 32'(tick[1]), 0);
        step();
        chk("sel3_2_tick1", 32'(tick[1]), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
